// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, opcode constant and FSM encoding for the fetch unit
package ifetch_pkg;
    localparam int XLEN = 32;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
endpackage

// File: rtl/ifetch_npc.sv
// ifetch_npc: next-PC for a fetched word, following JAL targets when enabled
module ifetch_npc
    import ifetch_pkg::*;
#(
    parameter bit PRED_JAL = 1'b1
) (
    input  logic [XLEN-1:0] w,
    input  logic [XLEN-1:0] a,
    output logic [XLEN-1:0] npc
);
    logic [XLEN-1:0] imm;
    assign imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    assign npc = a + ((PRED_JAL && w[6:0] == OP_JAL) ? imm : 32'd4);
endmodule

// File: rtl/ifetch.sv
// ifetch: single-outstanding instruction fetch feeding the instruction queue,
// with static JAL prediction and redirect handling.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter bit PRED_JAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rdy,
    input  logic [XLEN-1:0] mem_data,
    input  logic            que_full,
    output logic            inst_rdy,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc_out
);
    state_t state, state_n;
    logic [XLEN-1:0] pc, pc_n, mem_addr_n, inst_n, pc_out_n, hold_inst, hold_inst_n, hold_pc, hold_pc_n, npc;
    logic drop, drop_n, mem_req_n, inst_rdy_n;
    ifetch_npc #(.PRED_JAL(PRED_JAL)) u_npc (.w(mem_data), .a(mem_addr), .npc(npc));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            inst_rdy  <= 1'b0;
            inst      <= '0;
            pc_out    <= '0;
            hold_inst <= '0;
            hold_pc   <= '0;
        end else if (rdy) begin
            state     <= state_n;
            pc        <= pc_n;
            drop      <= drop_n;
            mem_req   <= mem_req_n;
            mem_addr  <= mem_addr_n;
            inst_rdy  <= inst_rdy_n;
            inst      <= inst_n;
            pc_out    <= pc_out_n;
            hold_inst <= hold_inst_n;
            hold_pc   <= hold_pc_n;
        end
    end
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        drop_n      = drop;
        mem_req_n   = mem_req;
        mem_addr_n  = mem_addr;
        inst_rdy_n  = 1'b0;
        inst_n      = inst;
        pc_out_n    = pc_out;
        hold_inst_n = hold_inst;
        hold_pc_n   = hold_pc;
        case (state)
            IDLE: begin
                if (jump_en) begin
                    pc_n = jump_pc;
                end else if (!que_full) begin
                    mem_req_n  = 1'b1;
                    mem_addr_n = pc;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                // a redirect never aborts the read; the reply is dropped instead
                if (jump_en) begin
                    pc_n   = jump_pc;
                    drop_n = 1'b1;
                end
                if (mem_rdy) begin
                    mem_req_n = 1'b0;
                    drop_n    = 1'b0;
                    state_n   = IDLE;
                    if (!drop && !jump_en) begin
                        pc_n = npc;
                        if (!que_full) begin
                            inst_rdy_n = 1'b1;
                            inst_n     = mem_data;
                            pc_out_n   = mem_addr;
                        end else begin
                            hold_inst_n = mem_data;
                            hold_pc_n   = mem_addr;
                            state_n     = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (jump_en) begin
                    pc_n    = jump_pc;
                    state_n = IDLE;
                end else if (!que_full) begin
                    inst_rdy_n = 1'b1;
                    inst_n     = hold_inst;
                    pc_out_n   = hold_pc;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed checks of the fetch unit against a latency-programmable memory model
module tb_ifetch;
    logic clk = 1'b0;
    logic rst, rdy, jump_en, que_full;
    logic [31:0] jump_pc;
    logic mem_req[2], mem_rdy[2], inst_rdy[2];
    logic [31:0] mem_addr[2], mem_data[2], inst[2], pc_out[2];
    logic [31:0] mem[1024];
    int cnt[2];
    int lat, cyc, n_push, n_cmp, n_err, np;
    logic [31:0] p, i;
    int c0, c1;

    ifetch #(.RESET_PC(32'h0), .PRED_JAL(1'b1)) u0 (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_en(jump_en), .jump_pc(jump_pc),
        .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_rdy(mem_rdy[0]), .mem_data(mem_data[0]),
        .que_full(que_full), .inst_rdy(inst_rdy[0]), .inst(inst[0]), .pc_out(pc_out[0]));
    ifetch #(.RESET_PC(32'h0), .PRED_JAL(1'b0)) u1 (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_en(jump_en), .jump_pc(jump_pc),
        .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_rdy(mem_rdy[1]), .mem_data(mem_data[1]),
        .que_full(que_full), .inst_rdy(inst_rdy[1]), .inst(inst[1]), .pc_out(pc_out[1]));

    always #5 clk = ~clk;

    // memory answers lat cycles after mem_req rises, reset by the same rst
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                mem_rdy[k]  <= 1'b0;
                mem_data[k] <= '0;
                cnt[k]      <= 0;
            end
        end else if (rdy) begin
            for (int k = 0; k < 2; k++) begin
                if (mem_rdy[k]) begin
                    mem_rdy[k] <= 1'b0;
                    cnt[k]     <= 0;
                end else if (mem_req[k]) begin
                    if (cnt[k] + 1 >= lat) begin
                        mem_rdy[k]  <= 1'b1;
                        mem_data[k] <= mem[mem_addr[k][11:2]];
                    end else begin
                        cnt[k] <= cnt[k] + 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdy && rst && inst_rdy[0]) n_push <= n_push + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        que_full = 1'b0;
        jump_en  = 1'b0;
        rst = 1'b0;
        #1;
        step();
        rst = 1'b1;
    endtask

    task automatic wait_rise(input logic [31:0] exp, input string tag);
        logic prev;
        logic hit;
        hit  = 1'b0;
        prev = mem_req[0];
        for (int k = 0; k < 50 && !hit; k++) begin
            step();
            if (mem_req[0] && !prev) hit = 1'b1;
            prev = mem_req[0];
        end
        chk(tag, {31'd0, hit, mem_addr[0]}, {31'd0, 1'b1, exp});
    endtask

    task automatic wait_push(output logic [31:0] pp, output logic [31:0] ii, output int cc);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            step();
            if (inst_rdy[0]) hit = 1'b1;
        end
        chk("push_seen", {63'd0, hit}, 64'd1);
        pp = pc_out[0];
        ii = inst[0];
        cc = cyc;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; n_push = 0;
        rdy = 1'b1; jump_en = 1'b0; jump_pc = '0; que_full = 1'b0; lat = 1;
        for (int k = 0; k < 1024; k++) mem[k] = 32'h13 | (k << 8);
        mem[4] = 32'h0200006F;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_mem_req", {63'd0, mem_req[0]}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr[0]}, 64'd0);
        chk("rst_inst_rdy", {63'd0, inst_rdy[0]}, 64'd0);
        chk("rst_inst", {32'd0, inst[0]}, 64'd0);
        chk("rst_pc_out", {32'd0, pc_out[0]}, 64'd0);
        step(); step();
        rst = 1'b1;
        // sequential fetch, L=1
        wait_push(p, i, c0);
        chk("seq0_pc", {32'd0, p}, 64'h0);
        chk("seq0_inst", {32'd0, i}, 64'h13);
        step();
        chk("seq0_one_cycle", {63'd0, inst_rdy[0]}, 64'd0);
        wait_push(p, i, c1);
        chk("seq1_pc", {32'd0, p}, 64'h4);
        chk("seq1_inst", {32'd0, i}, 64'h113);
        chk("seq1_gap", 64'(c1 - c0), 64'd3);
        c0 = c1;
        wait_push(p, i, c1);
        chk("seq2_pc", {32'd0, p}, 64'h8);
        chk("seq2_inst", {32'd0, i}, 64'h213);
        chk("seq2_gap", 64'(c1 - c0), 64'd3);
        // rdy=0 freezes everything, including the push strobe
        rdy = 1'b0;
        step(); step();
        chk("stall_inst_rdy", {63'd0, inst_rdy[0]}, 64'd1);
        chk("stall_pc_out", {32'd0, pc_out[0]}, 64'h8);
        chk("stall_mem_req", {63'd0, mem_req[0]}, 64'd0);
        rdy = 1'b1;
        // JAL at 0x10 with imm +0x20
        wait_push(p, i, c0);
        chk("seq3_pc", {32'd0, p}, 64'hC);
        wait_push(p, i, c0);
        chk("jal_pc", {32'd0, p}, 64'h10);
        chk("jal_inst", {32'd0, i}, 64'h0200006F);
        chk("jal_u1_pc", {32'd0, pc_out[1]}, 64'h10);
        chk("jal_u1_inst", {32'd0, inst[1]}, 64'h0200006F);
        step();
        chk("jal_pred_addr", {31'd0, mem_req[0], mem_addr[0]}, {31'd0, 1'b1, 32'h30});
        chk("jal_nopred_addr", {31'd0, mem_req[1], mem_addr[1]}, {31'd0, 1'b1, 32'h14});
        chk("jal_u1_one_cycle", {63'd0, inst_rdy[1]}, 64'd0);
        // queue full through the reply for 0x8
        do_reset(); lat = 1;
        wait_rise(32'h0, "t3_a0");
        wait_rise(32'h4, "t3_a4");
        wait_rise(32'h8, "t3_a8");
        que_full = 1'b1;
        np = n_push;
        step(); step();
        chk("hold_no_push", {63'd0, inst_rdy[0]}, 64'd0);
        chk("hold_req_low", {63'd0, mem_req[0]}, 64'd0);
        repeat (3) step();
        chk("hold_held", 64'(n_push), 64'(np));
        que_full = 1'b0;
        step();
        chk("hold_push", {63'd0, inst_rdy[0]}, 64'd1);
        chk("hold_push_pc", {32'd0, pc_out[0]}, 64'h8);
        chk("hold_push_inst", {32'd0, inst[0]}, 64'h213);
        step();
        chk("hold_single", {63'd0, inst_rdy[0]}, 64'd0);
        chk("hold_next_addr", {31'd0, mem_req[0], mem_addr[0]}, {31'd0, 1'b1, 32'hC});
        // redirect during WAIT, L=3
        do_reset(); lat = 3;
        wait_rise(32'h0, "t4_a0");
        wait_rise(32'h4, "t4_a4");
        np = n_push;
        jump_en = 1'b1; jump_pc = 32'h100;
        step();
        jump_en = 1'b0;
        wait_rise(32'h100, "t4_redirect");
        chk("t4_no_push", 64'(n_push), 64'(np));
        // redirect in the same cycle as mem_rdy
        do_reset(); lat = 1;
        wait_rise(32'h0, "t5a_a0");
        step();
        np = n_push;
        jump_en = 1'b1; jump_pc = 32'h200;
        step();
        jump_en = 1'b0;
        wait_rise(32'h200, "t5a_redirect");
        chk("t5a_no_push", 64'(n_push), 64'(np));
        // redirect in HOLD beats a push as que_full drops
        do_reset(); lat = 1;
        np = n_push;
        wait_rise(32'h0, "t5b_a0");
        que_full = 1'b1;
        step(); step();
        que_full = 1'b0;
        jump_en = 1'b1; jump_pc = 32'h300;
        step();
        jump_en = 1'b0;
        wait_rise(32'h300, "t5b_redirect");
        chk("t5b_no_push", 64'(n_push), 64'(np));
        // async reset while pushing and while a read is outstanding
        do_reset(); lat = 1;
        wait_push(p, i, c0);
        #1 rst = 1'b0;
        #1;
        chk("arst_inst_rdy", {63'd0, inst_rdy[0]}, 64'd0);
        chk("arst_pc_out", {32'd0, pc_out[0]}, 64'd0);
        step();
        rst = 1'b1;
        lat = 3;
        wait_rise(32'h0, "arst_first");
        step();
        #1 rst = 1'b0;
        #1;
        chk("arst_mem_req", {63'd0, mem_req[0]}, 64'd0);
        chk("arst_mem_addr", {32'd0, mem_addr[0]}, 64'd0);
        step();
        rst = 1'b1;
        wait_rise(32'h0, "arst_restart");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch unit and producer side of the instruction-queue push interface (inst_rdy / inst / pc).
- Holds the architectural fetch PC and issues one word-read at a time to the instruction memory port.
- Pushes each returned instruction with its PC into the queue, honouring queue-full backpressure.
- Applies static JAL prediction locally; handles redirects from the commit/branch unit, discarding wrong-path fetches.

Parameters:
- RESET_PC, 32'h0, fetch PC loaded on reset.
- PRED_JAL, 1, 1 = follow JAL targets at fetch; 0 = always pc+4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when 0 all state holds.
- jump_en  in  1  redirect request (mispredict/exception), single-cycle pulse.
- jump_pc  in  32  redirect target.
- mem_req  out  1  read request, level, held until mem_rdy.
- mem_addr  out  32  word address, stable while mem_req=1.
- mem_rdy  in  1  one-cycle pulse; mem_data valid this cycle.
- mem_data  in  32  returned instruction word.
- que_full  in  1  queue cannot accept a push next cycle.
- inst_rdy  out  1  one-cycle push strobe to queue.
- inst  out  32  pushed instruction.
- pc_out  out  32  PC of pushed instruction.

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, drop=0, mem_req=0, mem_addr=0, inst_rdy=0, inst=0, pc_out=0, hold buffer cleared. Reset mid-transaction abandons the outstanding read; memory is reset by the same signal.
- rdy=0: every register holds, including inst_rdy. The memory and the queue share the same rdy, so no mem_rdy arrives and no push is consumed while rdy=0.
- inst_rdy defaults to 0 every enabled cycle unless a push occurs; it is never high for two consecutive enabled cycles.
- FSM states IDLE, WAIT, HOLD:
  - IDLE:
    - jump_en: pc=jump_pc, stay in IDLE.
    - Else if !que_full: mem_req<=1, mem_addr<=pc, go to WAIT.
  - WAIT:
    - jump_en: pc=jump_pc, drop<=1. The request stays asserted (no abort). A later jump_en overwrites pc again.
    - mem_rdy && (drop || jump_en): discard data, mem_req<=0, drop<=0, go to IDLE.
    - mem_rdy && !drop && !jump_en && !que_full: inst_rdy<=1, inst<=mem_data, pc_out<=mem_addr, pc<=npc, mem_req<=0, go to IDLE.
    - mem_rdy && !drop && !jump_en && que_full: hold_inst<=mem_data, hold_pc<=mem_addr, pc<=npc, mem_req<=0, go to HOLD.
  - HOLD:
    - jump_en: discard the held instruction, pc=jump_pc, go to IDLE. A redirect beats a push in the same cycle.
    - Else if !que_full: push hold_inst/hold_pc, go to IDLE.
- Next PC (npc) is computed from the returned word w and its address a:
  - If PRED_JAL and w[6:0]==7'b1101111: npc = a + sext({w[31],w[19:12],w[20],w[30:21],1'b0}).
  - Otherwise npc = a+4.
  - Arithmetic is 32-bit modulo; wrap at 32'hFFFFFFFC to 0 is legal.
- Latency: IDLE→mem_req takes 1 cycle. With memory latency L (cycles from mem_req rising to mem_rdy), inst_rdy rises the cycle after mem_rdy. Best case is one instruction every L+2 cycles.
- que_full is sampled only at request start and at push time. The queue must assert it with at least one slot of margin, so that a request issued while not full can always complete.

Decomposition:
- Shared header:
  - opcode constant for JAL
  - instruction/address width define (32)
  - FSM state encodings (2-bit)
- Sub-module: ifetch_npc (combinational JAL-immediate extraction plus next-PC adder), reused later by a predictor.

Test Plan:
- Sequential fetch, L=1, que_full=0, RESET_PC=0 → pushes pc_out 0,4,8 with inst matching memory; inst_rdy pulses 1 cycle each, 3 cycles apart.
- JAL at 0x10 (imm=+0x20, word 32'h0200006F) → next mem_addr=0x30; with PRED_JAL=0 → next mem_addr=0x14.
- que_full=1 held through mem_rdy at addr 0x8 → HOLD, no inst_rdy. Deassert 3 cycles later → single push of pc_out=0x8 next cycle.
- jump_en (jump_pc=0x100) during WAIT for 0x4, L=3 → 0x4 data discarded (no inst_rdy); next mem_addr=0x100.
- jump_en in the same cycle as mem_rdy, and separately in HOLD while que_full drops → no push; next mem_addr=jump_pc.
- rst pulled low while mem_req=1 → mem_req, inst_rdy drop immediately (async). After release, first mem_addr=RESET_PC.
